trigger_unit: RTL and testbench

- Parametrised hardware trigger unit. Successor to the fixed two-trigger CSR block.
- Holds NUM_TRIG address/data-match triggers (mcontrol, type 2) with CSR and debugger access.
- Compares per-instruction PC and load/store addresses against each trigger. Produces a registered fire request to the exception/debug controller in the core.

---
 rtl/trig_pkg.sv | 61 ++++++
 rtl/trig_match.sv | 39 +++
 rtl/trigger_unit.sv | 200 ++++++++++++++++++++
 tb/tb_trigger_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared constants, tdata1 field layout and the stored mcontrol fields of a trigger.
package trig_pkg;

  localparam logic [11:0] TSELECT = 12'h7A0;
  localparam logic [11:0] TDATA1  = 12'h7A1;
  localparam logic [11:0] TDATA2  = 12'h7A2;
  localparam logic [11:0] TDATA3  = 12'h7A3;
  localparam logic [11:0] TINFO   = 12'h7A4;

  localparam int unsigned TD1_DMODE      = 27;
  localparam int unsigned TD1_HIT        = 20;
  localparam int unsigned TD1_SELECT     = 19;
  localparam int unsigned TD1_ACTION_LSB = 12;
  localparam int unsigned TD1_CHAIN      = 11;
  localparam int unsigned TD1_MATCH_LSB  = 7;
  localparam int unsigned TD1_M          = 6;
  localparam int unsigned TD1_EXECUTE    = 2;
  localparam int unsigned TD1_STORE      = 1;
  localparam int unsigned TD1_LOAD       = 0;

  localparam logic [3:0] MATCH_EQ = 4'd0;
  localparam logic [3:0] MATCH_GE = 4'd2;
  localparam logic [3:0] MATCH_LT = 4'd3;

  localparam logic [3:0] ACTION_BKPT = 4'd0;
  localparam logic [3:0] ACTION_DBG  = 4'd1;

  localparam logic [31:0] TDATA1_RST = 32'h2000_0000;
  localparam logic [31:0] TINFO_VAL  = 32'h0000_0004;

  // Only the writable state of tdata1; type and reserved bits are constant.
  typedef struct packed {
    logic       dmode;
    logic       hit;
    logic       select;
    logic       action;
    logic       chain;
    logic [3:0] match_op;
    logic       m;
    logic       execute;
    logic       store;
    logic       load;
  } mcontrol_t;

  function automatic logic [31:0] mc_pack(input mcontrol_t mc);
    logic [31:0] r;
    r = TDATA1_RST;
    r[TD1_DMODE]              = mc.dmode;
    r[TD1_HIT]                = mc.hit;
    r[TD1_SELECT]             = mc.select;
    r[TD1_ACTION_LSB +: 4]    = {3'b000, mc.action};
    r[TD1_CHAIN]              = mc.chain;
    r[TD1_MATCH_LSB +: 4]     = mc.match_op;
    r[TD1_M]                  = mc.m;
    r[TD1_EXECUTE]            = mc.execute;
    r[TD1_STORE]              = mc.store;
    r[TD1_LOAD]               = mc.load;
    return r;
  endfunction

endpackage

// File: rtl/trig_match.sv
// Single mcontrol comparator: checks pc and load/store value against tdata2.
module trig_match import trig_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  m,
  input  logic                  execute,
  input  logic                  load,
  input  logic                  store,
  input  logic [3:0]            match_op,
  input  logic [DATA_WIDTH-1:0] tdata2,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  pc_valid,
  input  logic [DATA_WIDTH-1:0] ls_value,
  input  logic                  ls_valid,
  input  logic                  ls_store,
  output logic                  match_c
);

  function automatic logic cmp(input logic [3:0] op,
                               input logic [DATA_WIDTH-1:0] v,
                               input logic [DATA_WIDTH-1:0] t);
    case (op)
      MATCH_GE: return v >= t;
      MATCH_LT: return v < t;
      default:  return v == t;
    endcase
  endfunction

  logic pc_hit;
  logic ls_hit;

  always_comb begin
    pc_hit  = execute && pc_valid && cmp(match_op, pc, tdata2);
    ls_hit  = ((load && !ls_store) || (store && ls_store)) && ls_valid &&
              cmp(match_op, ls_value, tdata2);
    match_c = m && (pc_hit || ls_hit);
  end

endmodule

// File: rtl/trigger_unit.sv
// NUM_TRIG mcontrol triggers with CSR access, chaining and a registered fire request.
// Define KRV_TRIG_DATA_MATCH_EN to add the ls_data port and data-value matching (select).
module trigger_unit import trig_pkg::*; #(
  parameter int unsigned NUM_TRIG   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TSEL_W     = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic [11:0]           csr_addr,
  input  logic                  csr_wr,
  input  logic                  csr_set,
  input  logic                  csr_clr,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic                  dbg_mode,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  pc_valid,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  input  logic                  ls_valid,
  input  logic                  ls_store,
`ifdef KRV_TRIG_DATA_MATCH_EN
  input  logic [DATA_WIDTH-1:0] ls_data,
`endif
  output logic                  trig_fire,
  output logic                  trig_action,
  output logic [TSEL_W-1:0]     trig_idx
);

  mcontrol_t             mc_q     [NUM_TRIG];
  logic [DATA_WIDTH-1:0] tdata2_q [NUM_TRIG];
  logic [TSEL_W-1:0]     tselect;

  mcontrol_t             cur_mc;
  mcontrol_t             mc_new;
  logic [DATA_WIDTH-1:0] wr_val;
  logic [31:0]           nv;
  logic                  protect;
  logic                  wr_tsel;
  logic                  wr_td1;
  logic                  wr_td2;
  logic [NUM_TRIG-1:0]   match_c;
  logic [NUM_TRIG-1:0]   hit_set;
  logic [NUM_TRIG-1:0]   run_mask;
  logic                  run_ok;
  logic                  fire_c;
  logic                  win_act;
  logic [TSEL_W-1:0]     win_idx;
  logic                  unused_bits;

  assign cur_mc = mc_q[tselect];

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      TSELECT: csr_rdata = DATA_WIDTH'(tselect);
      TDATA1:  csr_rdata = DATA_WIDTH'(mc_pack(cur_mc));
      TDATA2:  csr_rdata = tdata2_q[tselect];
      TINFO:   csr_rdata = DATA_WIDTH'(TINFO_VAL);
      default: csr_rdata = '0;
    endcase
  end

  // Set/clear act on the current read value, before any field legalisation.
  assign wr_val  = csr_set ? (csr_rdata | csr_wdata) :
                   csr_clr ? (csr_rdata & ~csr_wdata) : csr_wdata;
  assign nv      = 32'(wr_val);
  assign protect = cur_mc.dmode & ~dbg_mode;
  assign wr_tsel = csr_wr && (csr_addr == TSELECT) && (wr_val < DATA_WIDTH'(NUM_TRIG));
  assign wr_td1  = csr_wr && (csr_addr == TDATA1) && !protect;
  assign wr_td2  = csr_wr && (csr_addr == TDATA2) && !protect;

  assign unused_bits = ^{nv[31:28], nv[26:21], nv[19:16], nv[5:3]};

  always_comb begin
    mc_new         = '0;
    mc_new.dmode   = dbg_mode ? nv[TD1_DMODE] : cur_mc.dmode;
    mc_new.hit     = nv[TD1_HIT];
`ifdef KRV_TRIG_DATA_MATCH_EN
    mc_new.select  = nv[TD1_SELECT];
`endif
    mc_new.action  = (nv[TD1_ACTION_LSB +: 4] == ACTION_DBG);
    mc_new.chain   = (tselect == TSEL_W'(NUM_TRIG - 1)) ? 1'b0 : nv[TD1_CHAIN];
    case (nv[TD1_MATCH_LSB +: 4])
      MATCH_GE, MATCH_LT: mc_new.match_op = nv[TD1_MATCH_LSB +: 4];
      default:            mc_new.match_op = MATCH_EQ;
    endcase
    mc_new.m       = nv[TD1_M];
    mc_new.execute = nv[TD1_EXECUTE];
    mc_new.store   = nv[TD1_STORE];
    mc_new.load    = nv[TD1_LOAD];
  end

`ifdef KRV_TRIG_DATA_MATCH_EN
  logic [DATA_WIDTH-1:0] ls_data_q;
  logic                  ls_valid_q;
  logic                  ls_store_q;

  // Load return data arrives late, so data matches run one stage behind.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ls_data_q  <= '0;
      ls_valid_q <= 1'b0;
      ls_store_q <= 1'b0;
    end else begin
      ls_data_q  <= ls_data;
      ls_valid_q <= ls_valid;
      ls_store_q <= ls_store;
    end
  end
`endif

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
    logic [DATA_WIDTH-1:0] ls_value;
    logic                  ls_v;
    logic                  ls_st;
    logic                  raw_match;

`ifdef KRV_TRIG_DATA_MATCH_EN
    assign ls_value = mc_q[g].select ? ls_data_q  : ls_addr;
    assign ls_v     = mc_q[g].select ? ls_valid_q : ls_valid;
    assign ls_st    = mc_q[g].select ? ls_store_q : ls_store;
`else
    assign ls_value = ls_addr;
    assign ls_v     = ls_valid;
    assign ls_st    = ls_store;
`endif

    trig_match #(.DATA_WIDTH(DATA_WIDTH)) u_match (
      .m        (mc_q[g].m),
      .execute  (mc_q[g].execute),
      .load     (mc_q[g].load),
      .store    (mc_q[g].store),
      .match_op (mc_q[g].match_op),
      .tdata2   (tdata2_q[g]),
      .pc       (pc),
      .pc_valid (pc_valid),
      .ls_value (ls_value),
      .ls_valid (ls_v),
      .ls_store (ls_st),
      .match_c  (raw_match)
    );

    assign match_c[g] = raw_match & ~dbg_mode;
  end

  // Walk chain runs; the first fully-matching run wins and is attributed to its tail.
  always_comb begin
    fire_c   = 1'b0;
    win_idx  = '0;
    win_act  = 1'b0;
    hit_set  = '0;
    run_ok   = 1'b1;
    run_mask = '0;
    for (int k = 0; k < NUM_TRIG; k++) begin
      run_mask[k] = 1'b1;
      run_ok      = run_ok & match_c[k];
      if (!mc_q[k].chain) begin
        if (run_ok && !fire_c) begin
          fire_c  = 1'b1;
          win_idx = TSEL_W'(k);
          win_act = mc_q[k].action;
          hit_set = run_mask;
        end
        run_ok   = 1'b1;
        run_mask = '0;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      tselect <= '0;
      for (int i = 0; i < NUM_TRIG; i++) begin
        mc_q[i]     <= '0;
        tdata2_q[i] <= '0;
      end
    end else begin
      if (wr_tsel) tselect <= TSEL_W'(wr_val);
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (wr_td1 && (tselect == TSEL_W'(i))) mc_q[i] <= mc_new;
        else if (hit_set[i])                   mc_q[i].hit <= 1'b1;
        if (wr_td2 && (tselect == TSEL_W'(i))) tdata2_q[i] <= wr_val;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      trig_fire   <= 1'b0;
      trig_action <= 1'b0;
      trig_idx    <= '0;
    end else begin
      trig_fire   <= fire_c;
      trig_action <= win_act;
      trig_idx    <= win_idx;
    end
  end

endmodule

// File: tb/tb_trigger_unit.sv
// Directed bench for trigger_unit: CSR readback checks plus a fire scoreboard.
module tb_trigger_unit;
  import trig_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic [11:0] csr_addr = '0;
  logic        csr_wr = 1'b0;
  logic        csr_set = 1'b0;
  logic        csr_clr = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        dbg_mode = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic [31:0] ls_addr = '0;
  logic        ls_valid = 1'b0;
  logic        ls_store = 1'b0;
  logic [31:0] ls_data = '0;
  logic        trig_fire;
  logic        trig_action;
  logic [1:0]  trig_idx;

  trigger_unit dut (
    .cpu_clk     (cpu_clk),
    .cpu_rstn    (cpu_rstn),
    .csr_addr    (csr_addr),
    .csr_wr      (csr_wr),
    .csr_set     (csr_set),
    .csr_clr     (csr_clr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .dbg_mode    (dbg_mode),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .ls_addr     (ls_addr),
    .ls_valid    (ls_valid),
    .ls_store    (ls_store),
`ifdef KRV_TRIG_DATA_MATCH_EN
    .ls_data     (ls_data),
`endif
    .trig_fire   (trig_fire),
    .trig_action (trig_action),
    .trig_idx    (trig_idx)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct packed {
    logic       fire;
    logic [1:0] idx;
    logic       act;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Each driven cycle pushes the fire expected on the following edge.
  always @(posedge cpu_clk) begin : mon
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("trig_fire", 32'(trig_fire), 32'(e.fire));
      if (e.fire) begin
        chk("trig_idx", 32'(trig_idx), 32'(e.idx));
        chk("trig_action", 32'(trig_action), 32'(e.act));
      end
    end
  end

  task automatic csr_op(input logic [11:0] a, input logic [31:0] d, input logic s, input logic c);
    @(negedge cpu_clk);
    csr_addr = a; csr_wdata = d; csr_set = s; csr_clr = c; csr_wr = 1'b1;
    @(posedge cpu_clk); #2;
    csr_wr = 1'b0; csr_set = 1'b0; csr_clr = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_op(a, d, 1'b0, 1'b0);
  endtask

  task automatic csr_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    @(negedge cpu_clk);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic cyc(input logic pv, input logic [31:0] p, input logic lv,
                     input logic [31:0] la, input logic st,
                     input logic ef, input logic [1:0] ei, input logic ea);
    @(negedge cpu_clk);
    pc_valid = pv; pc = p; ls_valid = lv; ls_addr = la; ls_store = st;
    sb.push_back('{fire: ef, idx: ei, act: ea});
    @(posedge cpu_clk); #2;
    pc_valid = 1'b0; ls_valid = 1'b0;
  endtask

  task automatic idle(input logic ef, input logic [1:0] ei, input logic ea);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, ef, ei, ea);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_fire", 32'(trig_fire), 32'h0);
    chk("rst_idx", 32'(trig_idx), 32'h0);
    chk("rst_action", 32'(trig_action), 32'h0);
    repeat (2) @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    // Reset values and WARL tselect
    csr_check("rst_tselect", TSELECT, 32'h0);
    csr_check("rst_tdata1", TDATA1, 32'h2000_0000);
    csr_check("rst_tdata2", TDATA2, 32'h0);
    csr_check("rst_tinfo", TINFO, 32'h4);
    csr_check("rst_tdata3", TDATA3, 32'h0);
    csr_check("unmapped", 12'h7A5, 32'h0);
    csr_write(TSELECT, 32'd4);
    csr_check("tselect_warl", TSELECT, 32'h0);
    csr_write(TINFO, 32'h0);
    csr_check("tinfo_ro", TINFO, 32'h4);
    csr_write(TDATA3, 32'hFFFF_FFFF);
    csr_check("tdata3_ro", TDATA3, 32'h0);

    // Execute trigger 1 with debug action
    csr_write(TSELECT, 32'd1);
    csr_check("tselect_1", TSELECT, 32'h1);
    csr_write(TDATA2, 32'h100);
    csr_write(TDATA1, 32'h0000_1044);
    csr_check("t1_tdata1", TDATA1, 32'h2000_1044);
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 2'd1, 1'b1);
    idle(1'b0, 2'd0, 1'b0);
    csr_check("t1_hit", TDATA1, 32'h2010_1044);
    cyc(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    csr_write(TDATA1, 32'h0);

    // Chained range: trig0 >= 0x8000, trig1 < 0x9000, loads only
    csr_write(TSELECT, 32'd0);
    csr_write(TDATA2, 32'h8000);
    csr_write(TDATA1, 32'h0000_0941);
    csr_write(TSELECT, 32'd1);
    csr_write(TDATA2, 32'h9000);
    csr_write(TDATA1, 32'h0000_01C1);
    cyc(1'b0, 32'h0, 1'b1, 32'h8800, 1'b0, 1'b1, 2'd1, 1'b0);
    idle(1'b0, 2'd0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h9800, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h7000, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h8800, 1'b1, 1'b0, 2'd0, 1'b0);
    csr_check("chain_t1_hit", TDATA1, 32'h2010_01C1);
    csr_write(TDATA1, 32'h0);
    csr_write(TSELECT, 32'd0);
    csr_check("chain_t0_hit", TDATA1, 32'h2010_0941);
    csr_write(TDATA1, 32'h0);

    // dmode protection on trigger 2
    dbg_mode = 1'b1;
    csr_write(TSELECT, 32'd2);
    csr_write(TDATA1, 32'h0800_0044);
    csr_write(TDATA2, 32'h200);
    csr_check("dmode_set", TDATA1, 32'h2800_0044);
    dbg_mode = 1'b0;
    csr_write(TDATA2, 32'h55);
    csr_check("dmode_td2_prot", TDATA2, 32'h200);
    csr_write(TDATA1, 32'h0000_5044);
    csr_check("dmode_td1_prot", TDATA1, 32'h2800_0044);

    // WARL fields on trigger 3 (last trigger: chain hardwired)
    csr_write(TSELECT, 32'd3);
    csr_write(TDATA1, 32'h0800_5844);
    csr_check("warl_act_chain_dmode", TDATA1, 32'h2000_0044);
    csr_write(TDATA1, 32'h0000_0084);
    csr_check("warl_match", TDATA1, 32'h2000_0004);
    csr_op(TDATA1, 32'h41, 1'b1, 1'b0);
    csr_check("csr_set", TDATA1, 32'h2000_0045);
    csr_op(TDATA1, 32'h4, 1'b0, 1'b1);
    csr_check("csr_clr", TDATA1, 32'h2000_0041);

    // Priority: triggers 0 and 3 both match pc=0x40
    csr_write(TDATA2, 32'h40);
    csr_write(TDATA1, 32'h0000_1044);
    csr_write(TSELECT, 32'd0);
    csr_write(TDATA2, 32'h40);
    csr_write(TDATA1, 32'h0000_0044);
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0);
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0);
    idle(1'b0, 2'd0, 1'b0);
    csr_check("prio_t0_hit", TDATA1, 32'h2010_0044);
    csr_write(TSELECT, 32'd3);
    csr_check("prio_t3_nohit", TDATA1, 32'h2000_1044);
    csr_write(TSELECT, 32'd0);

    // CSR write to tdata1 on the hit-set edge wins, hit stays clear
    @(negedge cpu_clk);
    csr_write(TDATA1, 32'h0000_0044);
    @(negedge cpu_clk);
    pc = 32'h40; pc_valid = 1'b1;
    csr_addr = TDATA1; csr_wdata = 32'h0000_0044; csr_wr = 1'b1;
    sb.push_back('{fire: 1'b1, idx: 2'd0, act: 1'b0});
    @(posedge cpu_clk); #2;
    pc_valid = 1'b0; csr_wr = 1'b0;
    csr_check("wr_beats_hit", TDATA1, 32'h2000_0044);

    dbg_mode = 1'b1;
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(1'b0, 2'd0, 1'b0);
    dbg_mode = 1'b0;

    csr_write(TDATA1, 32'h0);
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 2'd3, 1'b1);
    idle(1'b0, 2'd0, 1'b0);

    // Data-value match (select) on trigger 0
    csr_write(TDATA2, 32'hDEAD);
    csr_write(TDATA1, 32'h0008_0042);
`ifdef KRV_TRIG_DATA_MATCH_EN
    csr_check("select_rw", TDATA1, 32'h2008_0042);
    ls_data = 32'hDEAD;
    cyc(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    ls_data = 32'h0;
    idle(1'b1, 2'd0, 1'b0);
    idle(1'b0, 2'd0, 1'b0);
`else
    csr_check("select_hardwired", TDATA1, 32'h2000_0042);
`endif

    // Reset in the middle of a fire pulse
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 2'd3, 1'b1);
    cpu_rstn = 1'b0;
    #1;
    chk("midrst_fire", 32'(trig_fire), 32'h0);
    chk("midrst_idx", 32'(trig_idx), 32'h0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    csr_check("midrst_tselect", TSELECT, 32'h0);
    csr_check("midrst_tdata1", TDATA1, 32'h2000_0000);
    csr_check("midrst_tdata2", TDATA2, 32'h0);

    for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge cpu_clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
